// File: rtl/ddr2_xfer_ctrl_if.sv
// ddr2_xfer_ctrl_if: request/acknowledge port between the transfer sequencer and the DDR2 wrapper.
//   req   : request level, held until the edge after ack
//   we    : 1 = write, 0 = read, valid while req=1
//   addr  : DDR2 word address
//   wdata : write data
//   ack   : single-cycle completion pulse
//   rdata : read data, valid in the ack cycle of a read
// master = sequencer side, slave = DDR2 wrapper side.
interface ddr2_xfer_ctrl_if #(parameter int ADDR_W = 27);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ack;
   logic [31:0]       rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ddr2_xfer_ctrl.sv
// ddr2_xfer_ctrl: CPU-mapped sequencer running an optional writeback write then a read on the DDR2 port.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   cpu_we    : single-cycle CPU store strobe
//   cpu_addr  : CPU byte address [14:0]
//   cpu_wdata : CPU store data
//   cpu_rdata : combinational register read mux
//   mem       : DDR2 req/ack port (master side)
//   busy      : transfer in progress, mirrors STATUS[0]
module ddr2_xfer_ctrl #(
   parameter int ADDR_W      = 27,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_we,
   input  logic [14:0]           cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   ddr2_xfer_ctrl_if.master      mem,
   output logic                  busy
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, WB, GAP, RD, FIN} state_t;

   state_t        state, nxt;
   logic [31:0]   wb_wdata, wb_addr, addr, rd_data;
   logic          wb_en, done, tmo;
   logic [CW-1:0] cnt;
   logic          wr, go, in_req, tmo_hit;

   assign wr      = cpu_we && !busy;
   assign go      = wr && cpu_addr == 15'h402C && cpu_wdata[0];
   assign in_req  = state == WB || state == RD;
   assign tmo_hit = in_req && !mem.ack && cnt == CW'(TIMEOUT_CYC - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;

   // busy is raised by go one edge before the FSM leaves IDLE
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = busy ? (wb_en ? WB : RD) : IDLE;
         WB:      nxt = mem.ack ? GAP : tmo_hit ? FIN : WB;
         GAP:     nxt = RD;
         RD:      nxt = (mem.ack || tmo_hit) ? FIN : RD;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wb_wdata <= '0;
         wb_addr  <= '0;
         wb_en    <= 1'b0;
         addr     <= '0;
         rd_data  <= '0;
         done     <= 1'b0;
         tmo      <= 1'b0;
         busy     <= 1'b0;
         cnt      <= '0;
      end else begin
         if (wr && cpu_addr == 15'h401C) wb_wdata <= cpu_wdata;
         if (wr && cpu_addr == 15'h4020) wb_addr <= cpu_wdata;
         if (wr && cpu_addr == 15'h4024) wb_en <= cpu_wdata[0];
         if (wr && cpu_addr == 15'h4028) addr <= cpu_wdata;
         if (go) begin
            done <= 1'b0;
            tmo  <= 1'b0;
            busy <= 1'b1;
         end
         cnt <= in_req ? cnt + 1'b1 : '0;
         if (tmo_hit) tmo <= 1'b1;
         if (state == RD && mem.ack) rd_data <= mem.rdata;
         // a timed-out transfer reports only the timeout flag
         if (state == FIN) begin
            busy <= 1'b0;
            done <= !tmo;
         end
      end

   // request outputs are registered from the next state so they hold steady for the whole request
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem.req   <= 1'b0;
         mem.we    <= 1'b0;
         mem.addr  <= '0;
         mem.wdata <= '0;
      end else begin
         mem.req <= nxt == WB || nxt == RD;
         mem.we  <= nxt == WB;
         if (nxt == WB) begin
            mem.addr  <= wb_addr[ADDR_W-1:0];
            mem.wdata <= wb_wdata;
         end else if (nxt == RD) mem.addr <= addr[ADDR_W-1:0];
      end

   always_comb
      cpu_rdata = cpu_addr == 15'h401C ? wb_wdata :
                  cpu_addr == 15'h4020 ? wb_addr :
                  cpu_addr == 15'h4024 ? {31'd0, wb_en} :
                  cpu_addr == 15'h4028 ? addr :
                  cpu_addr == 15'h4030 ? {29'd0, tmo, done, busy} :
                  cpu_addr == 15'h4034 ? rd_data : '0;
endmodule
